// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
// Module      : ula_seq
// Description : Registered ALU with valid/ready handshakes, iterative
//               shift-add multiply and restoring unsigned divide, Z/N/C/V.
//               Optional remainder output enabled by macro ULA_REM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ULAControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ULAResult,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
`ifdef ULA_REM_EN
  ,
  output logic [WIDTH-1:0] Rem
`endif
);

  localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     prem_q, prem_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
`ifdef ULA_REM_EN
  logic [WIDTH-1:0]     rem_q, rem_d;
`endif

  logic                 w_accept;
  logic [WIDTH:0]       w_sum, w_dif;
  logic                 w_slt;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]       w_shift, w_trial;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_prem_nxt, w_quo_nxt;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  assign w_sum = {1'b0, SrcA} + {1'b0, SrcB};
  assign w_dif = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
  assign w_slt = $signed(SrcA) < $signed(SrcB);

  // Multiply: b_q shifts right so bit 0 is always the current multiplier bit.
  assign w_acc_nxt = acc_q + (b_q[0] ? mcand_q : '0);

  // Divide: dividend bits leave a_q from the top while quotient bits enter at
  // the bottom; a borrow in bit WIDTH of the trial means "restore".
  assign w_shift    = {prem_q, a_q[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, b_q};
  assign w_fits     = ~w_trial[WIDTH];
  assign w_prem_nxt = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt  = {a_q[WIDTH-2:0], w_fits};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    prem_d  = prem_q;
    res_d   = res_q;
    c_d     = c_q;
    v_d     = v_q;
`ifdef ULA_REM_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (w_accept) begin
          op_d    = ULAControl;
          a_d     = SrcA;
          b_d     = SrcB;
          mcand_d = {{WIDTH{1'b0}}, SrcA};
          acc_d   = '0;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = DONE;
          c_d     = 1'b0;
          v_d     = 1'b0;
`ifdef ULA_REM_EN
          rem_d   = '0;
`endif
          case (ULAControl)
            OP_ADD: begin
              res_d = w_sum[WIDTH-1:0];
              c_d   = w_sum[WIDTH];
              v_d   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
              res_d = w_dif[WIDTH-1:0];
              c_d   = w_dif[WIDTH];
              v_d   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_dif[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  res_d = SrcA & SrcB;
            OP_OR:   res_d = SrcA | SrcB;
            OP_XOR:  res_d = SrcA ^ SrcB;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, w_slt};
            default: begin
              // MUL / DIVU: flags and result keep their old values until done
              state_d = BUSY;
              c_d     = c_q;
              v_d     = v_q;
            end
          endcase
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d   = w_acc_nxt;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end else begin
          a_d    = w_quo_nxt;
          prem_d = w_prem_nxt;
        end
        if (cnt_q == C_LAST) begin
          state_d = DONE;
          if (op_q == OP_MUL) begin
            res_d = w_acc_nxt[WIDTH-1:0];
            c_d   = |w_acc_nxt[2*WIDTH-1:WIDTH];
            v_d   = |w_acc_nxt[2*WIDTH-1:WIDTH];
`ifdef ULA_REM_EN
            rem_d = '0;
`endif
          end else begin
            // With B==0 every trial fits, so the remainder naturally ends as A.
            res_d = (b_q == '0) ? {WIDTH{1'b1}} : w_quo_nxt;
            c_d   = 1'b0;
            v_d   = (b_q == '0);
`ifdef ULA_REM_EN
            rem_d = w_prem_nxt;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    z_d = (res_d == '0);
    n_d = res_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prem_q  <= '0;
      res_q   <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef ULA_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      prem_q  <= prem_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
`ifdef ULA_REM_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign ULAResult = res_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign C         = c_q;
  assign V         = v_q;
`ifdef ULA_REM_EN
  assign Rem       = rem_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ula_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_seq
// Description : Scoreboard testbench for ula_seq (WIDTH=8); honours ULA_REM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA, SrcB;
  logic [2:0]   ULAControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ULAResult;
  logic         Z, N, C, V;
`ifdef ULA_REM_EN
  logic [W-1:0] Rem;
`endif

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ULAControl (ULAControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ULAResult  (ULAResult),
    .Z          (Z),
    .N          (N),
    .C          (C),
    .V          (V)
`ifdef ULA_REM_EN
    ,
    .Rem        (Rem)
`endif
  );

  typedef struct packed {
    logic [7:0] res;
    logic       z, n, c, v;
    logic [7:0] rem;
  } res_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic [3:0] znvc;
    logic [7:0] rem;
    int         lat;
  } vec_t;

  res_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model written from the arithmetic definitions, not the datapath.
  function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    res_t        r;
    int          sa, sb;
    int unsigned ua, ub, p;
    r  = '0;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: begin
        r.res = a + b;
        r.c   = (ua + ub) > 255;
        r.v   = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        r.res = a - b;
        r.c   = (ua >= ub);
        r.v   = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: r.res = a & b;
      3'd3: r.res = a | b;
      3'd4: r.res = a ^ b;
      3'd5: r.res = (sa < sb) ? 8'd1 : 8'd0;
      3'd6: begin
        p     = ua * ub;
        r.res = p[7:0];
        r.c   = (p > 255);
        r.v   = (p > 255);
      end
      default: begin
        if (ub == 0) begin
          r.res = 8'hFF;
          r.v   = 1'b1;
          r.rem = a;
        end else begin
          p     = ua / ub;
          r.res = p[7:0];
          p     = ua % ub;
          r.rem = p[7:0];
        end
      end
    endcase
`ifndef ULA_REM_EN
    r.rem = '0;
`endif
    r.z = (r.res == 8'h00);
    r.n = r.res[7];
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.res = ULAResult;
    r.z   = Z;
    r.n   = N;
    r.c   = C;
    r.v   = V;
`ifdef ULA_REM_EN
    r.rem = Rem;
`else
    r.rem = '0;
`endif
    return r;
  endfunction

  function automatic res_t pop_exp();
    if (sb_q.size() == 0) return '1;
    return sb_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, waits for the accept edge and then for out_valid.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output res_t got, output int lat);
    int guard;
    in_valid   = 1'b1;
    ULAControl = op;
    SrcA       = a;
    SrcB       = b;
    guard      = 0;
    #1;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #2;
      guard++;
    end
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (guard >= 50 || lat >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_op_timeout op=%0d guard=%0d lat=%0d required out_valid within 50", op, guard, lat);
    end
    got = observe();
  endtask

  task automatic test_reset();
    res_t got, exp;
    int   lat, bad;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({out_valid, ULAResult, Z, N, C, V} !== {1'b0, 8'h00, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state got=%h required=%h", {out_valid, ULAResult, Z, N, C, V}, {1'b0, 8'h00, 1'b1, 3'b000});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
    run_op(3'd0, 8'h03, 8'h04, got, lat);
    exp = pop_exp();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL pre_reset_add got=%h required=%h", got, exp);
    end
    tick();
    // Start a multiply, let the counter reach 3, then abort it asynchronously.
    in_valid   = 1'b1;
    ULAControl = 3'd6;
    SrcA       = 8'h05;
    SrcB       = 8'h06;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, ULAResult, Z} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async got=%h required=%h", {out_valid, ULAResult, Z}, {1'b0, 8'h00, 1'b1});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got=%b required=1", in_ready);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_abort_no_result got=%0d valid cycles required=0", bad);
    end
  endtask

  task automatic test_single_cycle();
    vec_t v[9];
    res_t got, exp;
    int   lat;
    v[0] = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 8'h00, 1};
    v[1] = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 8'h00, 1};
    v[2] = '{3'd1, 8'h05, 8'h07, 8'hFE, 4'b0100, 8'h00, 1};
    v[3] = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'b0011, 8'h00, 1};
    v[4] = '{3'd5, 8'hFF, 8'h01, 8'h01, 4'b0000, 8'h00, 1};
    v[5] = '{3'd5, 8'h01, 8'hFF, 8'h00, 4'b1000, 8'h00, 1};
    v[6] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 8'h00, 1};
    v[7] = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 4'b0100, 8'h00, 1};
    v[8] = '{3'd4, 8'hAA, 8'hAA, 8'h00, 4'b1000, 8'h00, 1};
    for (int i = 0; i < 9; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, got, lat);
      exp = pop_exp();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_sb[%0d] got=%h required=%h", i, got, exp);
      end
      n_tests++;
      if ({got.res, got.z, got.n, got.c, got.v} !== {v[i].res, v[i].znvc} || lat != v[i].lat) begin
        n_fail++;
        $display("FAIL single_vec[%0d] got res/znvc=%h lat=%0d required=%h lat=%0d",
                 i, {got.res, got.z, got.n, got.c, got.v}, lat, {v[i].res, v[i].znvc}, v[i].lat);
      end
      tick();
    end
  endtask

  task automatic test_multi_cycle();
    vec_t v[6];
    res_t got, exp;
    int   lat;
    v[0] = '{3'd6, 8'h0C, 8'h0B, 8'h84, 4'b0100, 8'h00, 9};
    v[1] = '{3'd6, 8'h10, 8'h10, 8'h00, 4'b1011, 8'h00, 9};
    v[2] = '{3'd6, 8'hFF, 8'hFF, 8'h01, 4'b0011, 8'h00, 9};
    v[3] = '{3'd7, 8'h64, 8'h07, 8'h0E, 4'b0000, 8'h02, 9};
    v[4] = '{3'd7, 8'h2A, 8'h00, 8'hFF, 4'b0101, 8'h2A, 9};
    v[5] = '{3'd7, 8'h07, 8'h09, 8'h00, 4'b1000, 8'h07, 9};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, got, lat);
      exp = pop_exp();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL multi_sb[%0d] got=%h required=%h", i, got, exp);
      end
      n_tests++;
      if ({got.res, got.z, got.n, got.c, got.v} !== {v[i].res, v[i].znvc} || lat != v[i].lat) begin
        n_fail++;
        $display("FAIL multi_vec[%0d] got res/znvc=%h lat=%0d required=%h lat=%0d",
                 i, {got.res, got.z, got.n, got.c, got.v}, lat, {v[i].res, v[i].znvc}, v[i].lat);
      end
`ifdef ULA_REM_EN
      n_tests++;
      if (got.rem !== v[i].rem) begin
        n_fail++;
        $display("FAIL multi_rem[%0d] got=%h required=%h", i, got.rem, v[i].rem);
      end
`endif
      tick();
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int   lat;
    out_ready = 1'b0;
    run_op(3'd0, 8'h12, 8'h34, got, lat);
    exp = pop_exp();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_first got=%h required=%h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({out_valid, in_ready, ULAResult} !== {1'b1, 1'b0, 8'h46}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got=%h required=%h", i, {out_valid, in_ready, ULAResult}, {1'b1, 1'b0, 8'h46});
      end
    end
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    ULAControl = 3'd4;
    SrcA       = 8'hF0;
    SrcB       = 8'h0F;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready got=%b required=1", in_ready);
    end
    sb_q.push_back(model(3'd4, 8'hF0, 8'h0F));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    got      = observe();
    exp      = pop_exp();
    n_tests++;
    if (out_valid !== 1'b1 || got !== exp || ULAResult !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_result got valid=%b res=%h required valid=1 res=%h", out_valid, got, exp);
    end
    tick();
  endtask

  task automatic test_random();
    int got_n = 0;
    fork
      begin : driver
        logic [2:0] op;
        logic [7:0] a, b;
        int         guard;
        bit         accepted;
        for (int i = 0; i < 200; i++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          op = 3'($urandom_range(0, 7));
          a  = 8'($urandom);
          b  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
          in_valid   = 1'b1;
          ULAControl = op;
          SrcA       = a;
          SrcB       = b;
          accepted   = 1'b0;
          guard      = 0;
          while (!accepted && guard < 200) begin
            #1;
            if (in_ready) begin
              accepted = 1'b1;
              sb_q.push_back(model(op, a, b));
            end
            @(posedge clk);
            #1;
            guard++;
          end
          in_valid = 1'b0;
          if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_accept_timeout req=%0d waited=%0d required accept", i, guard);
          end
        end
      end
      begin : consumer
        res_t obs, exp;
        int   cyc = 0;
        while (got_n < 200 && cyc < 20000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (out_valid && out_ready) begin
            obs = observe();
            exp = pop_exp();
            n_tests++;
            if (obs !== exp) begin
              n_fail++;
              $display("FAIL rand_result[%0d] got=%h required=%h", got_n, obs, exp);
            end
            got_n++;
          end
          @(posedge clk);
          #1;
          cyc++;
        end
        out_ready = 1'b1;
      end
    join
    n_tests++;
    if (got_n != 200 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count got=%0d results, %0d pending required=200, 0 pending", got_n, sb_q.size());
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    ULAControl = '0;
    out_ready  = 1'b1;
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor to the combinational 8-bit ULA.
- Adds a valid/ready handshake on both input and output.
- Adds iterative multi-cycle multiply and unsigned divide.
- Extends status to four flags: Z, N, C, V. It sits between the register-file read stage and the writeback stage and can stall the datapath on long operations.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and control presented.
- in_ready  output  1  block accepts a request this cycle.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- ULAControl  input  3  operation select.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- ULAResult  output  WIDTH  registered result.
- Z  output  1  result equals zero.
- N  output  1  ULAResult[WIDTH-1].
- C  output  1  carry / no-borrow / multiply-overflow.
- V  output  1  signed overflow / divide-by-zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, ULAResult=0, Z=1, N=0, C=0, V=0, internal counter/accumulators=0. Reset asserted mid-operation aborts it; no result is produced.
- Accept: a request is taken when in_valid && in_ready at a rising edge. SrcA, SrcB and ULAControl are captured; later changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE: on accept of a single-cycle op -> DONE. On accept of MUL/DIVU -> BUSY, counter=0.
  - BUSY: one iteration per cycle. When counter==WIDTH-1 -> DONE.
  - DONE: out_valid=1, outputs held stable. If out_ready && in_valid, accept the next request (back-to-back). Else if out_ready -> IDLE. Else stay.
- Latency, accept edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIVU: WIDTH+1 cycles.
- Operations (all modulo 2^WIDTH):
  - 000 ADD: A+B. C=carry out; V=signed overflow.
  - 001 SUB: A+~B+1. C=1 when no borrow (A>=B unsigned); V=signed overflow.
  - 010 AND, 011 OR, 100 XOR: C=0, V=0.
  - 101 SLT: signed A<B -> 1, else 0 (zero-extended). C=0, V=0. This replaces the previous unsigned compare.
  - 110 MUL: shift-add, one bit of B per cycle. Result = low WIDTH bits of the product. C=V=1 when the high WIDTH bits are nonzero.
  - 111 DIVU: restoring division, one quotient bit per cycle. Result = quotient. C=0, V=0.
- Divide by zero (B==0): still takes WIDTH+1 cycles. Result = all ones, V=1, C=0.
- Flag rule: Z and N are always derived from the final ULAResult and are registered with it.
- No default/illegal encoding exists; all 8 codes are defined.

Optional Feature:
- Macro ULA_REM_EN.
- Defined: adds output port Rem [WIDTH-1:0], registered with ULAResult.
  - DIVU: Rem = remainder.
  - Divide by zero: Rem = SrcA.
  - All other ops: Rem = 0.
  - Reset value 0.
- Undefined: port absent; the remainder register may be optimised away. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 pulsed mid-MUL (counter 3) -> out_valid=0, ULAResult=0, Z=1 immediately (async). After release, in_ready=1.
- ADD/SUB flags, WIDTH=8:
  - 0x7F+0x01 -> 0x80, N=1, V=1, C=0, 1-cycle latency.
  - 0xFF+0x01 -> 0x00, Z=1, C=1.
  - 0x05-0x07 -> 0xFE, C=0, N=1.
- SLT signed: A=0xFF(-1), B=0x01 -> 0x01. A=0x01, B=0xFF -> 0x00.
- MUL: 0x0C*0x0B -> 0x84, C=V=0, out_valid exactly 9 cycles after accept. 0x10*0x10 -> 0x00, Z=1, C=V=1.
- DIVU: 0x64/0x07 -> 0x0E (Rem=0x02 with ULA_REM_EN). 0x2A/0x00 -> 0xFF, V=1 (Rem=0x2A).
- Handshake:
  - out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (XOR 0xF0^0x0F) -> new request accepted that edge; next cycle out_valid=1, ULAResult=0xFF.
  - A random back-pressure run of 200 mixed ops matches the reference model.
